// File: rtl/board_frame_tx.sv
// -----------------------------------------------------------------------------
// board_frame_tx
//   Serial transmitter for the tic-tac-toe board state. On a trigger it
//   snapshots the nine active-low cell codes and five active-low status LEDs,
//   packs them into a 24-bit active-high payload with even parity, and shifts
//   a 4-byte frame (HEADER, P[7:0], P[15:8], P[23:16]) out 8N1, LSB first.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low
//   a_out..i_out   : per cell {!p1,!p2}, 2'b11 = empty
//   *_led          : active-low status LEDs
//   send_req       : one-cycle transmit request
//   tx             : serial line, idles high
//   tx_busy        : high while a frame is on the line
//   frame_done     : one-cycle pulse after the last stop bit
//   dbg_state_o    : current FSM state, for observation only
//
// Handshake: send_req is a single-cycle strobe with no ready. In IDLE (or in
// DONE) it starts a frame on that edge; at any other time it is remembered in
// one pending flag, and any number of such requests collapse into one frame.
// -----------------------------------------------------------------------------
module board_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter logic [7:0]  HEADER       = 8'hA5,
   parameter bit          AUTO_SEND    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] a_out,
   input  logic [1:0] b_out,
   input  logic [1:0] c_out,
   input  logic [1:0] d_out,
   input  logic [1:0] e_out,
   input  logic [1:0] f_out,
   input  logic [1:0] g_out,
   input  logic [1:0] h_out,
   input  logic [1:0] i_out,
   input  logic       p1_turn_led,
   input  logic       p2_turn_led,
   input  logic       p1_win_led,
   input  logic       p2_win_led,
   input  logic       grid_full_led,
   input  logic       send_req,
   output logic       tx,
   output logic       tx_busy,
   output logic       frame_done,
   output logic [2:0] dbg_state_o
);

   localparam int unsigned    CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [23:0]   frame_q, frame_d;
   logic [22:0]   last_q, last_d;
   logic          pending_q, pending_d;

   // Raw (active-low) view of the board, in payload bit order.
   logic [22:0] live_w;
   logic [22:0] payload_w;
   logic        trig_w;
   logic        wrap_w;
   logic        snap_w;
   logic [7:0]  cur_byte_w;

   assign live_w    = {grid_full_led, p2_win_led, p1_win_led, p2_turn_led, p1_turn_led,
                       i_out, h_out, g_out, f_out, e_out, d_out, c_out, b_out, a_out};
   assign payload_w = ~live_w;
   assign wrap_w    = (baud_q == BAUD_LAST);
   // A pending request, a fresh request, or a board that differs from the last
   // frame sent all start a frame; they are OR-ed so coincident causes give one frame.
   assign trig_w    = send_req | pending_q | (AUTO_SEND && (live_w != last_q));

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      frame_d   = frame_q;
      last_d    = last_q;
      pending_d = pending_q;
      snap_w    = 1'b0;

      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
         baud_d = wrap_w ? '0 : baud_q + CW'(1);
      end else begin
         baud_d = '0;
      end

      case (state_q)
         S_IDLE:  if (trig_w) snap_w = 1'b1;
         S_START: if (wrap_w) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
         end
         S_DATA:  if (wrap_w) begin
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
         end
         // Stop bits run straight into the next start bit with no idle gap.
         S_STOP:  if (wrap_w) begin
            if (byte_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               state_d = S_START;
               byte_d  = byte_q + 2'd1;
            end
         end
         S_DONE:  if (trig_w) snap_w = 1'b1;
                  else        state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (snap_w) begin
         state_d   = S_START;
         baud_d    = '0;
         bit_d     = 3'd0;
         byte_d    = 2'd0;
         frame_d   = {^payload_w, payload_w};
         last_d    = live_w;
         pending_d = 1'b0;
      end else if (send_req && state_q != S_IDLE) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_q     <= 3'd0;
         byte_q    <= 2'd0;
         frame_q   <= '0;
         last_q    <= '1;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         frame_q   <= frame_d;
         last_q    <= last_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      case (byte_q)
         2'd0:    cur_byte_w = HEADER;
         2'd1:    cur_byte_w = frame_q[7:0];
         2'd2:    cur_byte_w = frame_q[15:8];
         default: cur_byte_w = frame_q[23:16];
      endcase
   end

   // Outputs decode the registered state only, so reset forces tx high at once.
   always_comb begin
      tx = 1'b1;
      if (state_q == S_START)     tx = 1'b0;
      else if (state_q == S_DATA) tx = cur_byte_w[bit_q];
   end

   assign tx_busy     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
   assign frame_done  = (state_q == S_DONE);
   assign dbg_state_o = state_q;

endmodule
